// File: rtl/irq_pkg.sv
// Shared types and helpers for the irq_arbiter interrupt front end.
package irq_pkg;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_arb_state_t;

   localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

   function automatic logic [31:0] onehot(input int unsigned id, input int unsigned n_src);
      logic [31:0] v;
      v = '0;
      if (id < n_src && id < 32) v[id[4:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Rotating priority encoder: first set bit of cand scanning upward from start_ptr with wrap.
module irq_prio_sel
#(
   parameter int N_SRC = 16,
   parameter int ID_W  = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] cand,
   input  logic [ID_W-1:0]  start_ptr,
   output logic             valid,
   output logic [ID_W-1:0]  win_id
);

   always_comb begin
      int idx;
      valid  = 1'b0;
      win_id = '0;
      idx    = 0;
      for (int i = 0; i < N_SRC; i++) begin
         idx = i + int'(start_ptr);
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!valid && cand[idx]) begin
            valid  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source edge-captured interrupt arbiter feeding one request to the core.
// Define IRQ_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int          N_SRC      = 16,
   parameter logic [31:0] CAUSE_BASE = IRQ_CAUSE_BASE
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_SRC-1:0]         irq_src_i,
   input  logic [N_SRC-1:0]         irq_mask_i,
   input  logic                     irq_taken_i,
   input  logic                     irq_ret_i,
   output logic                     irq_o,
   output logic [31:0]              irq_cause_o,
   output logic [$clog2(N_SRC)-1:0] irq_id_o,
   output logic [N_SRC-1:0]         irq_ack_o,
   output logic                     busy_o
);

   localparam int ID_W = $clog2(N_SRC);

   irq_arb_state_t    state_q, state_d;
   logic [N_SRC-1:0]  pending_q, pending_d, pending_clr;
   logic [N_SRC-1:0]  src_q, rise, cand;
   logic              irq_q, irq_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [31:0]       cause_q, cause_d;
   logic [N_SRC-1:0]  ack_q, ack_d;
   logic              busy_q, busy_d;
   logic [ID_W-1:0]   start_ptr;
   logic              sel_valid;
   logic [ID_W-1:0]   win_id;

   irq_prio_sel #(.N_SRC(N_SRC), .ID_W(ID_W)) u_sel (
      .cand      (cand),
      .start_ptr (start_ptr),
      .valid     (sel_valid),
      .win_id    (win_id)
   );

`ifdef IRQ_ARB_RR_EN
   logic [ID_W-1:0] rr_q, rr_d;

   assign start_ptr = rr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) rr_q <= '0;
      else       rr_q <= rr_d;
   end
`else
   assign start_ptr = '0;
`endif

   // Next-state logic; a rise on the bit being cleared keeps it set.
   always_comb begin
      rise        = irq_src_i & ~src_q;
      cand        = pending_q & irq_mask_i;
      state_d     = state_q;
      pending_clr = '0;
      irq_d       = irq_q;
      id_d        = id_q;
      cause_d     = cause_q;
      ack_d       = '0;
`ifdef IRQ_ARB_RR_EN
      rr_d        = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               id_d    = win_id;
               cause_d = CAUSE_BASE + 32'(win_id);
               irq_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (irq_taken_i) begin
               irq_d       = 1'b0;
               pending_clr = N_SRC'(onehot(32'(id_q), N_SRC));
               state_d     = SERVICE;
            end else if (!irq_mask_i[id_q]) begin
               irq_d   = 1'b0;
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (irq_ret_i) begin
               ack_d   = N_SRC'(onehot(32'(id_q), N_SRC));
`ifdef IRQ_ARB_RR_EN
               rr_d    = (id_q == ID_W'(N_SRC - 1)) ? '0 : id_q + 1'b1;
`endif
               state_d = IDLE;
            end
         end
         default: begin
            irq_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
      pending_d = (pending_q & ~pending_clr) | rise;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
         src_q     <= '0;
         irq_q     <= 1'b0;
         id_q      <= '0;
         cause_q   <= CAUSE_BASE;
         ack_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         src_q     <= irq_src_i;
         irq_q     <= irq_d;
         id_q      <= id_d;
         cause_q   <= cause_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
      end
   end

   assign irq_o       = irq_q;
   assign irq_id_o    = id_q;
   assign irq_cause_o = cause_q;
   assign irq_ack_o   = ack_q;
   assign busy_o      = busy_q;

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt front end for the RISC-V core.
- Captures edge-triggered requests from up to N_SRC peripherals into pending bits. Selects one enabled pending source and presents it as a single request to the core interrupt controller.
- Holds the selection stable until the trap is taken, then waits for mret-return before acknowledging the source and arbitrating again.
- Sits between peripheral IRQ lines and the interrupt controller's irq_req_i / irq_o / irq_ret_o handshake.

Parameters:
- N_SRC, 16, number of interrupt sources (2..32).
- CAUSE_BASE, 32'h8000_0010, mcause value reported for source 0. Source k reports CAUSE_BASE + k.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- irq_src_i  in  N_SRC  raw peripheral request lines. Rising edge marks a request.
- irq_mask_i  in  N_SRC  per-source enable. 1 = may be selected.
- irq_taken_i  in  1  one-cycle pulse from the interrupt controller: trap entered for the current request.
- irq_ret_i  in  1  one-cycle pulse from the interrupt controller: mret completed.
- irq_o  out  1  request to the interrupt controller (drives irq_req_i).
- irq_cause_o  out  32  CAUSE_BASE + irq_id_o. Valid while irq_o or busy_o is high.
- irq_id_o  out  $clog2(N_SRC)  index of the selected source.
- irq_ack_o  out  N_SRC  one-hot, one-cycle acknowledge to the serviced source.
- busy_o  out  1  high in REQ and SERVICE.

Behaviour:
- Reset values:
  - irq_o=0, irq_id_o=0, irq_cause_o=CAUSE_BASE, irq_ack_o=0, busy_o=0.
  - pending=0, src_q=0, rr_ptr=0, state=IDLE.
- Edge capture:
  - src_q <= irq_src_i every cycle; rise = irq_src_i & ~src_q.
  - pending |= rise.
  - A line already high when reset is released produces a rise in the first cycle after reset.
  - Masked sources still latch pending; the mask gates selection only.
- Candidate set: cand = pending & irq_mask_i.
- FSM, all outputs registered:
  - IDLE: if cand != 0, select a winner (see Optional Feature), latch id and cause, set irq_o=1, go REQ. Otherwise stay.
  - REQ: irq_o, irq_id_o and irq_cause_o are held stable.
    - If irq_taken_i: irq_o<=0, clear pending[id], go SERVICE.
    - Else if irq_mask_i[id]==0: withdraw. irq_o<=0, pending kept, go IDLE.
  - SERVICE: irq_o=0, id and cause held.
    - If irq_ret_i: irq_ack_o<=onehot(id) for exactly one cycle, rr_ptr<=(id+1) mod N_SRC, go IDLE.
- Latency:
  - Rise at cycle t → pending at t+1 → irq_o high at t+2 (when IDLE).
  - irq_ret_i at t → irq_ack_o at t+1 → earliest next irq_o at t+2.
- Simultaneous events and boundaries:
  - A rise on the same bit as its clear (taken cycle) leaves the bit set; set wins.
  - A new rise of the serviced source during SERVICE re-pends it.
  - irq_taken_i outside REQ and irq_ret_i outside SERVICE are ignored.
  - irq_taken_i and a mask drop in the same REQ cycle: taken wins.
  - rr_ptr wraps from N_SRC-1 to 0.
  - When N_SRC is not a power of two, id is never ≥ N_SRC.
  - Reset mid-operation returns everything to reset values. No ack is issued and pending is lost.
- Nesting is not supported: at most one source is in flight.

Optional Feature:
- Macro: IRQ_ARB_RR_EN.
- Defined: round-robin selection. The winner is the first set bit of cand scanning upward from rr_ptr with wrap. rr_ptr updates on ack.
- Undefined: fixed priority. The lowest set index of cand wins. rr_ptr is not implemented.

Decomposition:
- Package irq_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_arb_state_t.
  - localparam IRQ_CAUSE_BASE = 32'h8000_0010.
  - function onehot(id, N_SRC).
- Sub-module irq_prio_sel: purely combinational.
  - Inputs: cand[N_SRC], start_ptr.
  - Outputs: valid, win_id.
  - Implementation: rotating priority encoder. With IRQ_ARB_RR_EN undefined, start_ptr is tied to 0.

Test Plan:
- Single source: N_SRC=16, mask=all ones, rise on src[5].
  - irq_o=1 two cycles later, irq_id_o=5, irq_cause_o=32'h8000_0015.
  - Pulse taken → irq_o=0.
  - Pulse ret → irq_ack_o=16'h0020 for one cycle.
- Contention, fixed priority: rise on src[3] and src[9] in the same cycle.
  - Id 3 is serviced first, then id 9.
  - Each gets exactly one ack.
- Contention, IRQ_ARB_RR_EN: after servicing id 9 (rr_ptr=10), rise on src[2] and src[12].
  - Id 12 wins before id 2.
- Withdraw: in REQ for id 4, drop mask[4] without taken.
  - irq_o=0 next cycle, pending[4] still set.
  - Restore mask → reissued with id 4.
- Re-pend and collisions: src[7] toggles low→high in the same cycle as irq_taken_i for id 7.
  - Ack at ret; irq_o reasserts with id 7.
  - Stray irq_ret_i in IDLE produces no ack.
- Reset mid-SERVICE: assert rst_i in SERVICE.
  - All outputs at reset values next cycle.
  - No ack issued.
